// File: rtl/microsequencer.sv
// Microsequencer: selects the next control-store address from the encoder, jump field,
// incrementer or current state. A bounded memory-wait hold traps to TRAP_STATE on timeout.
module microsequencer #(
  parameter int unsigned WAIT_LIMIT  = 16,
  parameter logic [6:0]  FETCH_STATE = 7'd1,
  parameter logic [6:0]  TRAP_STATE  = 7'd127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  N,
  input  logic [1:0]  S,
  input  logic        Inv,
  input  logic        IncRld,
  input  logic [6:0]  CR,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        cond_br,
  input  logic        cond_z,
  output logic [6:0]  curState,
  output logic [6:0]  incState,
  output logic        cond,
  output logic        timeout
);

  typedef enum logic [2:0] {
    NA_DECODE  = 3'b000,
    NA_FETCH   = 3'b001,
    NA_JUMP    = 3'b010,
    NA_NEXT    = 3'b011,
    NA_CJUMP   = 3'b100,
    NA_CDECODE = 3'b101,
    NA_WAIT    = 3'b110,
    NA_HALT    = 3'b111
  } nsel_e;

  localparam logic [4:0] LIMIT_M1 = 5'(WAIT_LIMIT - 1);

  nsel_e      nsel;
  logic [6:0] cur_q, cur_d;
  logic [6:0] inc_q, inc_d;
  logic [4:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       cond_sel;
  logic [6:0] enc_state;

  assign nsel = nsel_e'(N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q     <= 7'd0;
      inc_q     <= 7'd1;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      inc_q     <= inc_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    unique case (IR[31:26])
      6'h00:   enc_state = 7'd10;
      6'h08:   enc_state = 7'd50;
      6'h23:   enc_state = 7'd20;
      6'h2B:   enc_state = 7'd30;
      6'h04:   enc_state = 7'd40;
      6'h02:   enc_state = 7'd60;
      default: enc_state = FETCH_STATE;
    endcase
  end

  always_comb begin
    cur_d     = cur_q;
    wait_d    = '0;
    timeout_d = 1'b0;
    unique case (nsel)
      NA_DECODE:  cur_d = enc_state;
      NA_FETCH:   cur_d = FETCH_STATE;
      NA_JUMP:    cur_d = CR;
      NA_NEXT:    cur_d = inc_q;
      NA_CJUMP:   cur_d = cond ? CR : inc_q;
      NA_CDECODE: cur_d = cond ? enc_state : inc_q;
      NA_WAIT: begin
        // A completing condition wins over the limit, so a wait that ends on the last
        // permitted cycle never traps.
        if (cond) begin
          cur_d = inc_q;
        end else if (wait_q == LIMIT_M1) begin
          cur_d     = TRAP_STATE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 5'd1;
        end
      end
      NA_HALT:    cur_d = cur_q;
    endcase
    inc_d = IncRld ? cur_d + 7'd1 : inc_q;
  end

  always_comb begin
    unique case (S)
      2'b00: cond_sel = MOC;
      2'b01: cond_sel = cond_br;
      2'b10: cond_sel = cond_z;
      2'b11: cond_sel = 1'b0;
    endcase
    cond     = cond_sel ^ Inv;
    curState = cur_q;
    incState = inc_q;
    timeout  = timeout_q;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a vector table for single-edge next-address behaviour,
// plus hand-written sequences for wait-hold, timeout trap, wrap and mid-wait reset.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  N;
  logic [1:0]  S;
  logic        Inv, IncRld, MOC, cond_br, cond_z;
  logic [6:0]  CR;
  logic [31:0] IR;
  logic [6:0]  curState, incState, curState1, incState1;
  logic        cond, timeout, cond1, timeout1;

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk(clk), .reset(reset), .N(N), .S(S), .Inv(Inv), .IncRld(IncRld), .CR(CR), .IR(IR),
    .MOC(MOC), .cond_br(cond_br), .cond_z(cond_z), .curState(curState), .incState(incState),
    .cond(cond), .timeout(timeout)
  );

  microsequencer #(.WAIT_LIMIT(1)) dut1 (
    .clk(clk), .reset(reset), .N(N), .S(S), .Inv(Inv), .IncRld(IncRld), .CR(CR), .IR(IR),
    .MOC(MOC), .cond_br(cond_br), .cond_z(cond_z), .curState(curState1), .incState(incState1),
    .cond(cond1), .timeout(timeout1)
  );

  typedef struct {
    logic [2:0] n;
    logic [1:0] s;
    logic       inv;
    logic       incrld;
    logic [6:0] cr;
    logic [5:0] op;
    logic       moc;
    logic       br;
    logic       z;
    logic       exp_cond;
    logic [6:0] exp_cur;
    logic [6:0] exp_inc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] n, input logic [1:0] s, input logic inv,
                       input logic incrld, input logic [6:0] cr, input logic moc);
    N = n; S = s; Inv = inv; IncRld = incrld; CR = cr; MOC = moc;
  endtask

  function automatic vec_t mk(input logic [2:0] n, input logic [1:0] s, input logic inv,
                              input logic incrld, input logic [6:0] cr, input logic [5:0] op,
                              input logic moc, input logic br, input logic z,
                              input logic ec, input logic [6:0] ecur, input logic [6:0] einc);
    vec_t v;
    v.n = n; v.s = s; v.inv = inv; v.incrld = incrld; v.cr = cr; v.op = op;
    v.moc = moc; v.br = br; v.z = z; v.exp_cond = ec; v.exp_cur = ecur; v.exp_inc = einc;
    return v;
  endfunction

  initial begin
    //            N     S   Inv Inc CR     op     moc br z  cond cur  inc
    vecs.push_back(mk(3'd1, 2'd0, 0, 1, 7'd0,   6'h00, 0, 0, 0, 0, 7'd1,   7'd2));
    vecs.push_back(mk(3'd3, 2'd0, 0, 1, 7'd0,   6'h00, 0, 0, 0, 0, 7'd2,   7'd3));
    vecs.push_back(mk(3'd0, 2'd0, 0, 0, 7'd0,   6'h23, 0, 0, 0, 0, 7'd20,  7'd3));
    vecs.push_back(mk(3'd2, 2'd0, 0, 0, 7'd2,   6'h00, 0, 0, 0, 0, 7'd2,   7'd3));
    vecs.push_back(mk(3'd0, 2'd0, 0, 0, 7'd0,   6'h2B, 0, 0, 0, 0, 7'd30,  7'd3));
    vecs.push_back(mk(3'd2, 2'd0, 0, 0, 7'd2,   6'h00, 0, 0, 0, 0, 7'd2,   7'd3));
    vecs.push_back(mk(3'd0, 2'd0, 0, 0, 7'd0,   6'h3F, 0, 0, 0, 0, 7'd1,   7'd3));
    vecs.push_back(mk(3'd0, 2'd0, 0, 1, 7'd0,   6'h00, 0, 0, 0, 0, 7'd10,  7'd11));
    vecs.push_back(mk(3'd4, 2'd1, 0, 0, 7'd45,  6'h00, 0, 1, 0, 1, 7'd45,  7'd11));
    vecs.push_back(mk(3'd4, 2'd1, 1, 0, 7'd45,  6'h00, 0, 1, 0, 0, 7'd11,  7'd11));
    vecs.push_back(mk(3'd5, 2'd2, 0, 1, 7'd0,   6'h08, 0, 0, 1, 1, 7'd50,  7'd51));
    vecs.push_back(mk(3'd5, 2'd2, 0, 1, 7'd0,   6'h08, 0, 0, 0, 0, 7'd51,  7'd52));
    vecs.push_back(mk(3'd0, 2'd0, 0, 0, 7'd0,   6'h04, 0, 0, 0, 0, 7'd40,  7'd52));
    vecs.push_back(mk(3'd0, 2'd0, 0, 0, 7'd0,   6'h02, 0, 0, 0, 0, 7'd60,  7'd52));
    vecs.push_back(mk(3'd7, 2'd3, 1, 1, 7'd0,   6'h00, 0, 0, 0, 1, 7'd60,  7'd61));
    vecs.push_back(mk(3'd7, 2'd3, 0, 0, 7'd0,   6'h00, 0, 0, 0, 0, 7'd60,  7'd61));
    vecs.push_back(mk(3'd6, 2'd3, 1, 0, 7'd0,   6'h00, 0, 0, 0, 1, 7'd61,  7'd61));
    vecs.push_back(mk(3'd2, 2'd0, 0, 1, 7'd127, 6'h00, 0, 0, 0, 0, 7'd127, 7'd0));
    vecs.push_back(mk(3'd3, 2'd0, 0, 1, 7'd0,   6'h00, 0, 0, 0, 0, 7'd0,   7'd1));
    vecs.push_back(mk(3'd6, 2'd0, 0, 0, 7'd0,   6'h00, 1, 0, 0, 1, 7'd1,   7'd1));
    vecs.push_back(mk(3'd4, 2'd0, 1, 0, 7'd99,  6'h00, 0, 0, 0, 1, 7'd99,  7'd1));

    reset = 1'b1;
    drive(3'd0, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    IR = '0; cond_br = 1'b0; cond_z = 1'b0;
    step(); step();
    check("reset_cur", curState, 7'd0);
    check("reset_inc", incState, 7'd1);
    check("reset_timeout", timeout, 1'b0);
    reset = 1'b0;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].n, vecs[i].s, vecs[i].inv, vecs[i].incrld, vecs[i].cr, vecs[i].moc);
      IR = {vecs[i].op, 26'h15A5A5A};
      cond_br = vecs[i].br;
      cond_z = vecs[i].z;
      #1;
      check($sformatf("v%0d_cond", i), cond, vecs[i].exp_cond);
      step();
      check($sformatf("v%0d_cur", i), curState, vecs[i].exp_cur);
      check($sformatf("v%0d_inc", i), incState, vecs[i].exp_inc);
      check($sformatf("v%0d_timeout", i), timeout, 1'b0);
    end
    cond_br = 1'b0; cond_z = 1'b0; IR = '0;

    // wait-hold of three cycles, then completion
    drive(3'd2, 2'd0, 1'b0, 1'b1, 7'd70, 1'b0);
    step();
    check("wait_setup_cur", curState, 7'd70);
    check("wait_setup_inc", incState, 7'd71);
    drive(3'd6, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      check($sformatf("wait_hold%0d_cur", k), curState, 7'd70);
      check($sformatf("wait_hold%0d_timeout", k), timeout, 1'b0);
      if (k == 1) begin
        check("limit1_trap_cur", curState1, 7'd127);
        check("limit1_trap_timeout", timeout1, 1'b1);
      end
    end
    MOC = 1'b1;
    step();
    check("wait_done_cur", curState, 7'd71);
    check("wait_done_timeout", timeout, 1'b0);

    // timeout trap on the 16th held edge, twice back to back
    drive(3'd2, 2'd0, 1'b0, 1'b1, 7'd5, 1'b0);
    step();
    drive(3'd6, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned k = 1; k <= 15; k++) begin
        step();
        check($sformatf("trap%0d_hold%0d_timeout", r, k), timeout, 1'b0);
      end
      check($sformatf("trap%0d_prelimit_cur", r), curState, (r == 0) ? 7'd5 : 7'd127);
      step();
      check($sformatf("trap%0d_cur", r), curState, 7'd127);
      check($sformatf("trap%0d_timeout", r), timeout, 1'b1);
    end
    drive(3'd3, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    step();
    check("post_trap_cur", curState, 7'd6);
    check("post_trap_timeout", timeout, 1'b0);

    // condition arrives on the limit cycle: normal completion
    drive(3'd2, 2'd0, 1'b0, 1'b1, 7'd5, 1'b0);
    step();
    drive(3'd6, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    for (int unsigned k = 1; k <= 15; k++) step();
    MOC = 1'b1;
    step();
    check("limit_cond_cur", curState, 7'd6);
    check("limit_cond_timeout", timeout, 1'b0);

    // reset mid-wait after 5 holds, then confirm the wait counter restarted
    drive(3'd2, 2'd0, 1'b0, 1'b1, 7'd33, 1'b0);
    step();
    drive(3'd6, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    for (int unsigned k = 1; k <= 5; k++) step();
    check("prereset_cur", curState, 7'd33);
    #3 reset = 1'b1;
    #1;
    check("midwait_reset_cur", curState, 7'd0);
    check("midwait_reset_inc", incState, 7'd1);
    check("midwait_reset_timeout", timeout, 1'b0);
    step();
    reset = 1'b0;
    for (int unsigned k = 1; k <= 15; k++) begin
      step();
      check($sformatf("postreset_hold%0d_timeout", k), timeout, 1'b0);
    end
    check("postreset_hold_cur", curState, 7'd0);
    step();
    check("postreset_trap_cur", curState, 7'd127);
    check("postreset_trap_timeout", timeout, 1'b1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
